// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage memory access controller.
//   mem_op_t    : EX-stage memory operation encoding (2'b11 is reserved and
//                 is decoded as NOP by the users of this package)
//   bus_state_t : bus master FSM states
//   BUS_*       : shared-bus pin polarities (strobes are active-low)
//   is_mem_op() : true for LDW/STW
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_OP_NOP = 2'b00,
        MEM_OP_LDW = 2'b01,
        MEM_OP_STW = 2'b10
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        ACCESS = 2'b10,
        DONE   = 2'b11
    } bus_state_t;

    localparam logic BUS_ASSERT   = 1'b0;
    localparam logic BUS_DEASSERT = 1'b1;
    localparam logic BUS_RW_READ  = 1'b1;
    localparam logic BUS_RW_WRITE = 1'b0;

    localparam int TMO_CNT_W = 8;

    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == MEM_OP_LDW) || (op == MEM_OP_STW);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_bus_master_fsm.sv
// Shared-bus master: request/grant/strobe/ready handshake with access timeout.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   go_i              start a transfer (only honoured in IDLE)
//   flush_i, stall_i  pipeline control (abort in REQ, release/hold in DONE)
//   rw_i, addr_i,     transfer attributes, latched on the IDLE->REQ edge
//   wr_data_i
//   bus_grant_n_i     bus grant, active-low
//   bus_rdy_n_i       transfer done, active-low
//   bus_rd_data_i     read data, valid with bus_rdy_n_i low
//   state_o           current FSM state
//   rd_buf_o          captured load data (0 after a timeout)
//   bus_err_o         one-cycle pulse in the first DONE cycle after a timeout
//   bus_req_n_o, bus_as_n_o, bus_rw_o, bus_addr_o, bus_wr_data_o  bus pins
module bus_master_fsm
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 30,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              rw_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              bus_grant_n_i,
    input  logic              bus_rdy_n_i,
    input  logic [DATA_W-1:0] bus_rd_data_i,
    output bus_state_t        state_o,
    output logic [DATA_W-1:0] rd_buf_o,
    output logic              bus_err_o,
    output logic              bus_req_n_o,
    output logic              bus_as_n_o,
    output logic              bus_rw_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wr_data_o
);

    // Counter value seen in the last permitted ACCESS cycle.
    localparam logic [TMO_CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYC == 0) ? '1 : TMO_CNT_W'(TIMEOUT_CYC - 1);

    bus_state_t           state_q, state_d;
    logic                 req_n_q, req_n_d;
    logic                 as_n_q, as_n_d;
    logic                 rw_q, rw_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rd_buf_q, rd_buf_d;
    logic                 err_q, err_d;
    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            req_n_q  <= BUS_DEASSERT;
            as_n_q   <= BUS_DEASSERT;
            rw_q     <= BUS_RW_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_buf_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_n_q  <= req_n_d;
            as_n_q   <= as_n_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_buf_q <= rd_buf_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_n_d  = req_n_q;
        as_n_d   = BUS_DEASSERT;   // strobe is a single-cycle pulse
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_buf_d = rd_buf_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (go_i) begin
                    state_d = REQ;
                    req_n_d = BUS_ASSERT;
                    rw_d    = rw_i;
                    addr_d  = addr_i;
                    wdata_d = wr_data_i;
                end
            end
            REQ: begin
                // A flush wins over a grant arriving in the same cycle.
                if (flush_i) begin
                    state_d = IDLE;
                    req_n_d = BUS_DEASSERT;
                end else if (bus_grant_n_i == BUS_ASSERT) begin
                    state_d = ACCESS;
                    as_n_d  = BUS_ASSERT;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                // Flush is ignored here: the slave must see the transfer end.
                if (bus_rdy_n_i == BUS_ASSERT) begin
                    if (rw_q == BUS_RW_READ) begin
                        rd_buf_d = bus_rd_data_i;
                    end
                    state_d = DONE;
                    req_n_d = BUS_DEASSERT;
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == TO_LAST)) begin
                    err_d    = 1'b1;
                    rd_buf_d = '0;
                    state_d  = DONE;
                    req_n_d  = BUS_DEASSERT;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Never re-request from DONE: the EX op is still the one just served.
                if (flush_i || !stall_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o       = state_q;
    assign rd_buf_o      = rd_buf_q;
    assign bus_err_o     = err_q;
    assign bus_req_n_o   = req_n_q;
    assign bus_as_n_o    = as_n_q;
    assign bus_rw_o      = rw_q;
    assign bus_addr_o    = addr_q;
    assign bus_wr_data_o = wdata_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access controller: decodes the EX memory op, checks word
// alignment, runs LDW/STW on the shared bus and requests pipeline stalls.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall, flush             pipeline control
//   ex_en, ex_mem_op         EX valid and memory op (00 NOP, 01 LDW, 10 STW, 11 NOP)
//   ex_mem_wr                store data
//   ex_out                   byte address for LDW/STW, pass-through data otherwise
//   out                      to mem_reg: load data, 0 for stores, ex_out otherwise
//   miss_align               memory op with a non-word-aligned address
//   busy                     stall request while a transfer is outstanding
//   bus_err                  one-cycle pulse after an access timeout
//   bus_req_, bus_grant_, bus_as_, bus_rw, bus_addr, bus_wr_data,
//   bus_rd_data, bus_rdy_    shared bus (trailing underscore = active-low)
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 30,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_en,
    input  logic [1:0]        ex_mem_op,
    input  logic [DATA_W-1:0] ex_mem_wr,
    input  logic [DATA_W-1:0] ex_out,
    output logic [DATA_W-1:0] out,
    output logic              miss_align,
    output logic              busy,
    output logic              bus_err,
    output logic              bus_req_,
    input  logic              bus_grant_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    bus_state_t        state;
    logic [DATA_W-1:0] rd_buf;
    logic              mem_op;
    logic              go;

    assign mem_op     = ex_en && is_mem_op(ex_mem_op);
    assign miss_align = mem_op && (ex_out[1:0] != 2'b00);
    assign go         = mem_op && !miss_align && !flush;

    // DONE is deliberately not busy so mem_reg captures the result that cycle.
    assign busy = ((state == IDLE) && go) || (state == REQ) || (state == ACCESS);

    always_comb begin
        out = ex_out;
        if (ex_mem_op == MEM_OP_LDW) begin
            out = (state == DONE) ? rd_buf : '0;
        end else if (ex_mem_op == MEM_OP_STW) begin
            out = '0;
        end
    end

    bus_master_fsm #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_bus_master_fsm (
        .clk           (clk),
        .rst           (rst),
        .go_i          (go),
        .flush_i       (flush),
        .stall_i       (stall),
        .rw_i          (ex_mem_op == MEM_OP_LDW),
        .addr_i        (ex_out[ADDR_W+1:2]),
        .wr_data_i     (ex_mem_wr),
        .bus_grant_n_i (bus_grant_),
        .bus_rdy_n_i   (bus_rdy_),
        .bus_rd_data_i (bus_rd_data),
        .state_o       (state),
        .rd_buf_o      (rd_buf),
        .bus_err_o     (bus_err),
        .bus_req_n_o   (bus_req_),
        .bus_as_n_o    (bus_as_),
        .bus_rw_o      (bus_rw),
        .bus_addr_o    (bus_addr),
        .bus_wr_data_o (bus_wr_data)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a reactive bus slave with chosen grant/ready
// latencies plus a transaction-level expectation model.
module tb_mem_access_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 30;
    localparam int TMO    = 8;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LDW = 2'b01;
    localparam logic [1:0] OP_STW = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic              clk = 1'b0;
    logic              rst, stall, flush, ex_en;
    logic [1:0]        ex_mem_op;
    logic [DATA_W-1:0] ex_mem_wr, ex_out, out;
    logic              miss_align, busy, bus_err;
    logic              bus_req_, bus_grant_, bus_as_, bus_rw, bus_rdy_;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wr_data, bus_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .ex_en       (ex_en),
        .ex_mem_op   (ex_mem_op),
        .ex_mem_wr   (ex_mem_wr),
        .ex_out      (ex_out),
        .out         (out),
        .miss_align  (miss_align),
        .busy        (busy),
        .bus_err     (bus_err),
        .bus_req_    (bus_req_),
        .bus_grant_  (bus_grant_),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_)
    );

    // One EX op from the IDLE cycle through DONE (plus nstall held DONE cycles).
    // gdly: REQ cycles the slave withholds grant; rdly: ACCESS cycles before ready.
    task automatic run_op(input logic en, input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gdly, input int rdly, input int nstall);
        logic        is_mem, mis, exp_go, is_ld, tmo;
        logic [31:0] exp_out;
        int          exp_busy, nbusy, nas, rc, ac;
        logic        granted, finished;
        is_mem   = en && (op == OP_LDW || op == OP_STW);
        mis      = is_mem && (addr[1:0] != 2'b00);
        exp_go   = is_mem && !mis;
        is_ld    = (op == OP_LDW);
        tmo      = (rdly >= TMO);
        exp_busy = 1 + (gdly + 1) + (tmo ? TMO : rdly + 1);
        nbusy = 0; nas = 0; rc = 0; ac = 0; granted = 1'b0; finished = 1'b0;

        @(negedge clk);
        ex_en = en; ex_mem_op = op; ex_out = addr; ex_mem_wr = wdata;
        #1;
        n_checks++;
        if (bus_req_ !== 1'b1) begin
            n_fail++; $display("FAIL idle_req: got %b expected 1", bus_req_);
        end
        n_checks++;
        if (miss_align !== mis) begin
            n_fail++; $display("FAIL miss_align: got %b expected %b (addr %h)", miss_align, mis, addr);
        end
        n_checks++;
        if (busy !== exp_go) begin
            n_fail++; $display("FAIL busy_start: got %b expected %b", busy, exp_go);
        end
        if (!exp_go) begin
            exp_out = (op == OP_NOP || op == OP_RSV) ? addr : 32'h0;
            n_checks++;
            if (out !== exp_out) begin
                n_fail++; $display("FAIL out_nobus: got %h expected %h (op %b)", out, exp_out, op);
            end
            return;
        end

        exp_out = (is_ld && !tmo) ? rdata : 32'h0;
        for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                #1;
            end
            if (!busy) begin
                finished = 1'b1;
            end else begin
                nbusy++;
                if (bus_as_ === 1'b0) nas++;
                if (bus_req_ === 1'b0) begin
                    n_checks++;
                    if (bus_addr !== addr[31:2] || bus_rw !== is_ld) begin
                        n_fail++;
                        $display("FAIL bus_attr: got addr %h rw %b expected addr %h rw %b",
                                 bus_addr, bus_rw, addr[31:2], is_ld);
                    end
                    if (!is_ld) begin
                        n_checks++;
                        if (bus_wr_data !== wdata) begin
                            n_fail++; $display("FAIL bus_wr_data: got %h expected %h", bus_wr_data, wdata);
                        end
                    end
                end
                bus_grant_  = 1'b1;
                bus_rdy_    = 1'b1;
                bus_rd_data = $urandom;
                if (granted) begin
                    if (ac == rdly) begin
                        bus_rdy_    = 1'b0;
                        bus_rd_data = rdata;
                    end
                    ac++;
                end else if (bus_req_ === 1'b0) begin
                    if (rc == gdly) begin
                        bus_grant_ = 1'b0;
                        granted    = 1'b1;
                    end
                    rc++;
                end
            end
        end
        bus_grant_ = 1'b1;
        bus_rdy_   = 1'b1;

        n_checks++;
        if (!finished) begin
            n_fail++; $display("FAIL busy_bound: busy still 1 after 64 cycles expected release");
        end
        n_checks++;
        if (nbusy !== exp_busy) begin
            n_fail++; $display("FAIL busy_len: got %0d cycles expected %0d", nbusy, exp_busy);
        end
        n_checks++;
        if (nas !== 1) begin
            n_fail++; $display("FAIL as_pulse: got %0d strobe cycles expected 1", nas);
        end
        n_checks++;
        if (out !== exp_out) begin
            n_fail++; $display("FAIL done_out: got %h expected %h", out, exp_out);
        end
        n_checks++;
        if (bus_err !== tmo) begin
            n_fail++; $display("FAIL bus_err: got %b expected %b", bus_err, tmo);
        end
        n_checks++;
        if (bus_req_ !== 1'b1) begin
            n_fail++; $display("FAIL done_req: got %b expected 1", bus_req_);
        end

        if (nstall > 0) begin
            stall = 1'b1;
            for (int i = 0; i < nstall; i++) begin
                @(negedge clk);
                #1;
                if (i == nstall - 1) stall = 1'b0;
                n_checks++;
                if (out !== exp_out || busy !== 1'b0 || bus_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_hold: got out %h busy %b err %b expected out %h busy 0 err 0",
                             out, busy, bus_err, exp_out);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; ex_en = 1'b0;
        ex_mem_op = OP_NOP; ex_out = 32'h55AA_1234; ex_mem_wr = 32'h0;
        bus_grant_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1 || bus_rw !== 1'b1) begin
            n_fail++; $display("FAIL reset_pins: got req %b as %b rw %b expected 1 1 1", bus_req_, bus_as_, bus_rw);
        end
        n_checks++;
        if (bus_addr !== '0 || bus_wr_data !== '0) begin
            n_fail++; $display("FAIL reset_data: got addr %h wdata %h expected 0 0", bus_addr, bus_wr_data);
        end
        n_checks++;
        if (busy !== 1'b0 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctl: got busy %b err %b expected 0 0", busy, bus_err);
        end
        n_checks++;
        if (out !== 32'h55AA_1234) begin
            n_fail++; $display("FAIL reset_out: got %h expected 55aa1234", out);
        end
    endtask

    task automatic test_load();
        run_op(1'b1, OP_LDW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    endtask

    task automatic test_store();
        run_op(1'b1, OP_STW, 32'h204, 32'h12345678, 32'hFFFF_FFFF, 1, 2, 0);
    endtask

    task automatic test_misalign();
        run_op(1'b1, OP_LDW, 32'h102, 32'h0, 32'h0, 0, 0, 0);
        @(negedge clk);
        ex_en = 1'b0;
        #1;
        n_checks++;
        if (bus_req_ !== 1'b1) begin
            n_fail++; $display("FAIL misalign_req: got %b expected 1", bus_req_);
        end
    endtask

    task automatic test_flush_req();
        int nas;
        nas = 0;
        @(negedge clk);
        ex_en = 1'b1; ex_mem_op = OP_LDW; ex_out = 32'h380; flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) flush = 1'b1;
            #1;
            if (bus_as_ === 1'b0) nas++;
            n_checks++;
            if (bus_req_ !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL flush_req_wait: got req %b busy %b expected 0 1", bus_req_, busy);
            end
        end
        @(negedge clk);
        flush = 1'b0; ex_en = 1'b0;
        #1;
        if (bus_as_ === 1'b0) nas++;
        n_checks++;
        if (bus_req_ !== 1'b1 || busy !== 1'b0 || nas !== 0) begin
            n_fail++; $display("FAIL flush_req_abort: got req %b busy %b strobes %0d expected 1 0 0",
                               bus_req_, busy, nas);
        end
    endtask

    task automatic test_timeout();
        run_op(1'b1, OP_LDW, 32'h10, 32'h0, 32'hA5A5_A5A5, 0, 100, 0);
        @(negedge clk);
        ex_en = 1'b0;
        #1;
        n_checks++;
        if (bus_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_after: got err %b busy %b expected 0 0", bus_err, busy);
        end
    endtask

    task automatic test_flush_done();
        run_op(1'b1, OP_LDW, 32'h40, 32'h0, 32'hCAFEF00D, 0, 1, 0);
        stall = 1'b1; flush = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (out !== 32'h0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_done: got out %h busy %b expected 0 0", out, busy);
        end
        stall = 1'b0; flush = 1'b0; ex_en = 1'b0;
    endtask

    task automatic test_reset_in_access();
        @(negedge clk);
        ex_en = 1'b1; ex_mem_op = OP_LDW; ex_out = 32'h300;
        @(negedge clk);
        #1;
        bus_grant_ = 1'b0;
        @(negedge clk);
        #1;
        bus_grant_ = 1'b1;
        n_checks++;
        if (bus_as_ !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_setup: got as %b busy %b expected 0 1", bus_as_, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ex_en = 1'b0;
        #1;
        n_checks++;
        if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1 || busy !== 1'b0 || bus_addr !== '0) begin
            n_fail++; $display("FAIL rst_access: got req %b as %b busy %b addr %h expected 1 1 0 0",
                               bus_req_, bus_as_, busy, bus_addr);
        end
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, OP_STW, 32'h800, 32'h0BAD_CAFE, 32'h0, 0, 0, 0);
        run_op(1'b1, OP_LDW, 32'h804, 32'h0, 32'h1357_9BDF, 0, 0, 2);
        run_op(1'b1, OP_LDW, 32'h808, 32'h0, 32'h2468_ACE0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            run_op($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), a, $urandom, $urandom,
                   $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3),
                   $urandom_range(0, 2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misalign();
        test_flush_req();
        test_timeout();
        test_flush_done();
        test_reset_in_access();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
